aib_avmm_cmd_engine: RTL and testbench
======================================

// Module: aib_avmm_cmd_engine
// PURPOSE
//   Single-outstanding AVMM command engine between the calibration FSMs
//   (register config, phase adjust) and the AIB PHY AVMM slave port.
//   Accepts WRITE, READ and READ-MODIFY-WRITE (RMW) commands over a valid/ready handshake.
//   Runs the AVMM protocol, including waitrequest stalls and readdatavalid.
//   Returns one response per command, with timeout error reporting.
// PARAMETERS
//   ADDR_W       17    AVMM address width
//   DATA_W       32    AVMM data width; byteenable width is DATA_W/8
//   TIMEOUT_CYC  1024  max cycles spent in any single bus state before abort (>=2)
// PORTS
//   clk                 in   1         clock
//   rst_n               in   1         asynchronous, active-low reset
//   cmd_valid           in   1         command present
//   cmd_ready           out  1         engine can accept a command (IDLE only)
//   cmd_op              in   2         2'b00 WR, 2'b01 RD, 2'b10 RMW, 2'b11 reserved (treated as RD)
//   cmd_addr            in   ADDR_W    target address
//   cmd_wdata           in   DATA_W    write data (WR) / insert data (RMW)
//   cmd_mask            in   DATA_W    RMW: bits set = replace with cmd_wdata; ignored otherwise
//   cmd_be              in   DATA_W/8  byteenable for every AVMM access of this command
//   rsp_valid           out  1         one-cycle response pulse; no backpressure
//   rsp_rdata           out  DATA_W    read data (RD, RMW original value); 0 on WR/error
//   rsp_err             out  1         command aborted on timeout
//   busy                out  1         high whenever state != IDLE
//   avmm_write_o        out  1         AVMM write
//   avmm_read_o         out  1         AVMM read
//   avmm_address_o      out  ADDR_W    AVMM address
//   avmm_writedata_o    out  DATA_W    AVMM write data
//   avmm_byteenable_o   out  DATA_W/8  AVMM byteenable
//   avmm_waitrequest_i  in   1         slave stall
//   avmm_readdata_i     in   DATA_W    read data
//   avmm_readdatavalid_i in  1         read data qualifier
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0 except cmd_ready=1; latched cmd, timer, rdata = 0.
//   - Accept on cmd_valid&&cmd_ready; latch op/addr/wdata/mask/be.
//     Next state: WR->WRITE, RD/RMW->RD_REQ.
//   - AVMM outputs are decoded from registered state/latched fields only.
//     They never depend combinationally on cmd_* inputs.
//   - WRITE: avmm_write_o=1, addr/data/be held. Leave when waitrequest=0 -> RESP.
//   - RD_REQ: avmm_read_o=1. Leave when waitrequest=0:
//     - if readdatavalid is high in that same cycle, capture data now (zero-latency slave);
//     - otherwise -> RD_WAIT.
//   - RD_WAIT: buses idle. On readdatavalid, capture readdata.
//     Then RD -> RESP; RMW -> RMW_WR.
//   - RMW_WR: writedata = (rdata & ~mask) | (wdata & mask); same addr/be.
//     Leave when waitrequest=0 -> RESP. rsp_rdata = original read value.
//   - RESP: rsp_valid=1 for exactly one cycle -> IDLE. cmd_ready returns 1 next cycle.
//   - Latency with waitrequest=0:
//     - WR: accept @0, write @1, rsp @2.
//     - RD (data in 1 cycle): read @1, rdv @2, rsp @3.
//   - Timer: cleared on every state change. Increments in WRITE/RD_REQ/RD_WAIT/RMW_WR.
//     At count==TIMEOUT_CYC-1 in any of these states: drop read/write, go to RESP,
//     rsp_err=1, rsp_rdata=0. In RMW, a timeout during the read skips the write.
//   - Late readdatavalid outside RD_REQ/RD_WAIT is ignored.
//   - Reserved op is executed as RD (no error flag).
//   - Reset mid-command: immediate return to IDLE; bus strobes drop asynchronously;
//     no response is issued.
// STRUCTURE
//   - Package aib_avmm_pkg: op_e {OP_WR, OP_RD, OP_RMW, OP_RSVD};
//     state_e {IDLE, WRITE, RD_REQ, RD_WAIT, RMW_WR, RESP}.
//   - Sub-module aib_timeout_cnt: clear/enable inputs, expired output, TIMEOUT_CYC param.
//   - Rest is one FSM plus a command/data latch in this file.
// TESTING
//   1 WR addr=0x00208 data=0xA5A5_0001 be=0xF, waitrequest=0
//     -> write strobe exactly 1 cycle; rsp_valid @cycle2; err=0.
//   2 RD addr=0x1F000, waitrequest=1 for 3 cycles, rdv 2 cycles later with 0xDEAD_BEEF
//     -> read strobe 4 cycles; rsp_rdata=0xDEAD_BEEF.
//   3 RMW read returns 0xFFFF_0000, mask=0x0000_00FF, wdata=0x0000_0012
//     -> write data 0xFFFF_0012; rsp_rdata=0xFFFF_0000.
//   4 RD with rdv never asserted, TIMEOUT_CYC=16
//     -> rsp_err=1 after 16 RD_WAIT cycles, rdata=0; next command accepted normally.
//   5 Zero-latency slave: rdv high in the same cycle waitrequest drops
//     -> data captured, no RD_WAIT visit.
//   6 rst_n low while in WRITE with waitrequest=1
//     -> write strobe drops immediately; no rsp_valid; cmd_ready=1 after release.

Source files
------------

// File: rtl/aib_avmm_pkg.sv
// Shared types for the AIB AVMM command engine: command opcodes and FSM states.
package aib_avmm_pkg;

    typedef enum logic [1:0] {
        OP_WR   = 2'b00,
        OP_RD   = 2'b01,
        OP_RMW  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RMW_WR  = 3'd4,
        RESP    = 3'd5
    } state_e;

    // States in which the engine is waiting on the slave and the watchdog runs.
    function automatic logic is_bus_state(input state_e s);
        return (s == WRITE) || (s == RD_REQ) || (s == RD_WAIT) || (s == RMW_WR);
    endfunction

endpackage

// File: rtl/aib_timeout_cnt.sv
// Per-state watchdog: counts enabled cycles since the last clear and flags the last allowed one.
module aib_timeout_cnt #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LAST)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/aib_avmm_cmd_engine.sv
// Single-outstanding AVMM command engine (WR / RD / RMW) with per-state timeout abort.
module aib_avmm_cmd_engine
    import aib_avmm_pkg::*;
#(
    parameter int ADDR_W      = 17,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W-1:0]     cmd_mask,
    input  logic [DATA_W/8-1:0]   cmd_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  avmm_write_o,
    output logic                  avmm_read_o,
    output logic [ADDR_W-1:0]     avmm_address_o,
    output logic [DATA_W-1:0]     avmm_writedata_o,
    output logic [DATA_W/8-1:0]   avmm_byteenable_o,
    input  logic                  avmm_waitrequest_i,
    input  logic [DATA_W-1:0]     avmm_readdata_i,
    input  logic                  avmm_readdatavalid_i
);

    localparam int BE_W = DATA_W / 8;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mask_q, mask_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                tmo_expired;
    logic                tmo_clear;
    logic                tmo_enable;
    logic                rd_hit;
    logic                bus_abort;
    logic                is_rmw;
    logic [DATA_W-1:0]   rmw_wdata;

    assign is_rmw     = (op_q == OP_RMW);
    assign tmo_enable = is_bus_state(state_q);
    assign tmo_clear  = (state_d != state_q);
    assign rmw_wdata  = (rdata_q & ~mask_q) | (wdata_q & mask_q);

    // Read data is taken in RD_REQ only for a zero-latency slave (same cycle the stall drops).
    assign rd_hit = avmm_readdatavalid_i &&
                    (((state_q == RD_REQ) && !avmm_waitrequest_i) || (state_q == RD_WAIT));

    // A completing handshake on the last allowed cycle wins over the timeout.
    assign bus_abort = tmo_expired &&
                       ((state_q == RD_WAIT) ? !avmm_readdatavalid_i : avmm_waitrequest_i);

    aib_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = (op_e'(cmd_op) == OP_WR) ? WRITE : RD_REQ;
                end
            end
            WRITE, RMW_WR: begin
                if (!avmm_waitrequest_i || bus_abort) begin
                    state_d = RESP;
                end
            end
            RD_REQ: begin
                if (!avmm_waitrequest_i) begin
                    if (rd_hit) begin
                        state_d = is_rmw ? RMW_WR : RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else if (bus_abort) begin
                    state_d = RESP;
                end
            end
            RD_WAIT: begin
                if (rd_hit) begin
                    state_d = is_rmw ? RMW_WR : RESP;
                end else if (bus_abort) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if ((state_q == IDLE) && cmd_valid) begin
            op_d    = op_e'(cmd_op);
            addr_d  = cmd_addr;
            wdata_d = cmd_wdata;
            mask_d  = cmd_mask;
            be_d    = cmd_be;
            rdata_d = '0;
            err_d   = 1'b0;
        end else if (bus_abort) begin
            rdata_d = '0;
            err_d   = 1'b1;
        end else if (rd_hit) begin
            rdata_d = avmm_readdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        cmd_ready         = (state_q == IDLE);
        busy              = (state_q != IDLE);
        avmm_read_o       = (state_q == RD_REQ);
        avmm_write_o      = (state_q == WRITE) || (state_q == RMW_WR);
        avmm_address_o    = '0;
        avmm_byteenable_o = '0;
        avmm_writedata_o  = '0;
        rsp_valid         = (state_q == RESP);
        rsp_rdata         = '0;
        rsp_err           = 1'b0;
        if (avmm_read_o || avmm_write_o) begin
            avmm_address_o    = addr_q;
            avmm_byteenable_o = be_q;
        end
        if (state_q == WRITE) begin
            avmm_writedata_o = wdata_q;
        end else if (state_q == RMW_WR) begin
            avmm_writedata_o = rmw_wdata;
        end
        if (state_q == RESP) begin
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
        end
    end

endmodule

// File: tb/tb_aib_avmm_cmd_engine.sv
// Self-checking bench: reactive AVMM slave, transaction-level timing model, directed + random commands.
module tb_aib_avmm_cmd_engine;
    import aib_avmm_pkg::*;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int T      = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'b00;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic [DATA_W-1:0] cmd_mask = '0;
    logic [BE_W-1:0]   cmd_be = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              avmm_write_o;
    logic              avmm_read_o;
    logic [ADDR_W-1:0] avmm_address_o;
    logic [DATA_W-1:0] avmm_writedata_o;
    logic [BE_W-1:0]   avmm_byteenable_o;
    logic              avmm_waitrequest_i = 1'b0;
    logic [DATA_W-1:0] avmm_readdata_i = '0;
    logic              avmm_readdatavalid_i = 1'b0;

    always #5 clk = ~clk;

    aib_avmm_cmd_engine #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_op               (cmd_op),
        .cmd_addr             (cmd_addr),
        .cmd_wdata            (cmd_wdata),
        .cmd_mask             (cmd_mask),
        .cmd_be               (cmd_be),
        .rsp_valid            (rsp_valid),
        .rsp_rdata            (rsp_rdata),
        .rsp_err              (rsp_err),
        .busy                 (busy),
        .avmm_write_o         (avmm_write_o),
        .avmm_read_o          (avmm_read_o),
        .avmm_address_o       (avmm_address_o),
        .avmm_writedata_o     (avmm_writedata_o),
        .avmm_byteenable_o    (avmm_byteenable_o),
        .avmm_waitrequest_i   (avmm_waitrequest_i),
        .avmm_readdata_i      (avmm_readdata_i),
        .avmm_readdatavalid_i (avmm_readdatavalid_i)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Slave plan for the current command: stall cycles on read/write, rdv delay, read value.
    int          p_r = 0, p_d = 0, p_w = 0;
    bit          p_zero = 1'b0;
    logic [31:0] p_rval = '0;

    // Reactive slave, updated on the falling edge from the DUT's registered strobes.
    int s_rcnt = 0, s_wcnt = 0, s_dcnt = 0;
    bit s_pend = 1'b0;
    always @(negedge clk) begin
        avmm_readdatavalid_i = 1'b0;
        avmm_readdata_i      = $urandom;
        if (!rst_n) begin
            avmm_waitrequest_i = 1'b0;
            s_rcnt = 0; s_wcnt = 0; s_dcnt = 0; s_pend = 1'b0;
        end else if (avmm_read_o) begin
            avmm_waitrequest_i = (s_rcnt < p_r);
            s_rcnt++;
            if (!avmm_waitrequest_i) begin
                if (p_zero) begin
                    avmm_readdatavalid_i = 1'b1;
                    avmm_readdata_i      = p_rval;
                end else begin
                    s_pend = 1'b1;
                    s_dcnt = 0;
                end
            end
        end else if (avmm_write_o) begin
            avmm_waitrequest_i   = (s_wcnt < p_w);
            s_wcnt++;
            avmm_readdatavalid_i = ($urandom_range(0, 3) == 0);
        end else if (s_pend) begin
            avmm_waitrequest_i = $urandom_range(0, 1) == 1;
            if (s_dcnt == p_d) begin
                avmm_readdatavalid_i = 1'b1;
                avmm_readdata_i      = p_rval;
            end
            s_dcnt++;
        end else begin
            avmm_waitrequest_i   = $urandom_range(0, 1) == 1;
            avmm_readdatavalid_i = ($urandom_range(0, 3) == 0);
        end
        if (rsp_valid) begin
            s_rcnt = 0; s_wcnt = 0; s_dcnt = 0; s_pend = 1'b0;
        end
    end

    // Expected timeline of the active command, cycle k=1 being the first cycle after accept.
    bit          active = 1'b0;
    int          k = 0;
    logic [16:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rdata;
    bit          e_err;
    int          e_rs, e_rl, e_ws, e_wl, e_rsp;
    int          obs_rd, obs_wr, obs_wait, obs_rsp_k;
    logic [31:0] obs_wdata, obs_rdata;
    logic        obs_err;
    int          done_cnt = 0;
    int          rsp_pulses = 0;

    always @(negedge clk) begin
        if (rsp_valid) rsp_pulses++;
        if (!rst_n) begin
            active = 1'b0;
        end else if (active) begin
            bit exp_rd, exp_wr;
            k++;
            exp_rd = (e_rl != 0) && (k >= e_rs) && (k < e_rs + e_rl);
            exp_wr = (e_wl != 0) && (k >= e_ws) && (k < e_ws + e_wl);
            chk("read_strobe", avmm_read_o, exp_rd);
            chk("write_strobe", avmm_write_o, exp_wr);
            chk("rsp_valid_timing", rsp_valid, k == e_rsp);
            chk("busy_active", busy, 1'b1);
            chk("ready_active", cmd_ready, 1'b0);
            if (avmm_read_o || avmm_write_o) begin
                chk("bus_address", avmm_address_o, e_addr);
                chk("bus_byteenable", avmm_byteenable_o, e_be);
            end
            if (avmm_write_o) begin
                chk("bus_writedata", avmm_writedata_o, e_wd);
                obs_wdata = avmm_writedata_o;
            end
            if (avmm_read_o) obs_rd++;
            if (avmm_write_o) obs_wr++;
            if (busy && !avmm_read_o && !avmm_write_o && !rsp_valid) obs_wait++;
            if (rsp_valid && obs_rsp_k == 0) begin
                obs_rsp_k = k;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
            end
            if (k == e_rsp) begin
                chk("rsp_rdata", rsp_rdata, e_rdata);
                chk("rsp_err", rsp_err, e_err);
                active = 1'b0;
                done_cnt++;
            end
        end else begin
            chk("idle_ready", cmd_ready, 1'b1);
            chk("idle_busy", busy, 1'b0);
            chk("idle_bus", {avmm_read_o, avmm_write_o, rsp_valid}, 3'b000);
            if (cmd_valid && cmd_ready) begin
                op_e op;
                int  t;
                op      = op_e'(cmd_op);
                e_addr  = cmd_addr;
                e_be    = cmd_be;
                e_rs = 0; e_rl = 0; e_ws = 0; e_wl = 0; e_err = 1'b0;
                if (op == OP_WR) begin
                    e_ws  = 1;
                    e_wl  = imin(p_w + 1, T);
                    e_err = (p_w >= T);
                    t     = 1 + e_wl;
                    e_wd  = cmd_wdata;
                end else begin
                    e_rs = 1;
                    e_rl = imin(p_r + 1, T);
                    t    = 1 + e_rl;
                    e_wd = (p_rval & ~cmd_mask) | (cmd_wdata & cmd_mask);
                    if (p_r >= T) begin
                        e_err = 1'b1;
                    end else begin
                        if (!p_zero) begin
                            t += imin(p_d + 1, T);
                            e_err = (p_d >= T);
                        end
                        if (!e_err && op == OP_RMW) begin
                            e_ws  = t;
                            e_wl  = imin(p_w + 1, T);
                            t    += e_wl;
                            e_err = (p_w >= T);
                        end
                    end
                end
                e_rsp   = t;
                e_rdata = (e_err || op == OP_WR) ? 32'h0 : p_rval;
                obs_rd = 0; obs_wr = 0; obs_wait = 0; obs_rsp_k = 0;
                obs_wdata = '0; obs_rdata = '0; obs_err = 1'b0;
                k      = 0;
                active = 1'b1;
            end
        end
    end

    int base_done = 0;

    task automatic issue(input logic [1:0] op, input logic [16:0] a, input logic [31:0] wd,
                         input logic [31:0] m, input logic [3:0] be, input int r, input bit z,
                         input int d, input int w, input logic [31:0] rv);
        bit got;
        @(posedge clk); #2;
        p_r = r; p_zero = z; p_d = d; p_w = w; p_rval = rv;
        cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = m; cmd_be = be;
        cmd_valid = 1'b1;
        base_done = done_cnt;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("cmd_ready_bound", 1'b0, 1'b1);
        @(posedge clk); #2;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_addr  = 17'($urandom);
        cmd_wdata = $urandom;
        cmd_mask  = $urandom;
        cmd_be    = 4'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (done_cnt != base_done) return;
        end
        chk("rsp_wait_bound", 1'b0, 1'b1);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 9))
            0:       return $urandom_range(14, 17);
            1:       return T - 1;
            2:       return T;
            default: return $urandom_range(0, 4);
        endcase
    endfunction

    initial begin
        int p0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobes", {avmm_read_o, avmm_write_o, rsp_valid, rsp_err}, 4'b0000);
        chk("rst_address", avmm_address_o, 17'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Plain write, no stall.
        issue(2'b00, 17'h00208, 32'hA5A5_0001, 32'h0, 4'hF, 0, 1'b0, 0, 0, 32'h0);
        wait_done();
        chk("t1_rsp_cycle", obs_rsp_k, 2);
        chk("t1_write_cycles", obs_wr, 1);
        chk("t1_err", obs_err, 1'b0);
        chk("t1_wdata", obs_wdata, 32'hA5A5_0001);

        // Read with 3 stall cycles, data two cycles after the request completes.
        issue(2'b01, 17'h1F000, 32'h0, 32'h0, 4'hF, 3, 1'b0, 1, 0, 32'hDEAD_BEEF);
        wait_done();
        chk("t2_read_cycles", obs_rd, 4);
        chk("t2_rdata", obs_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp_cycle", obs_rsp_k, 7);

        // Read-modify-write.
        issue(2'b10, 17'h00040, 32'h0000_0012, 32'h0000_00FF, 4'hF, 0, 1'b0, 0, 0, 32'hFFFF_0000);
        wait_done();
        chk("t3_wdata", obs_wdata, 32'hFFFF_0012);
        chk("t3_rdata", obs_rdata, 32'hFFFF_0000);
        chk("t3_rsp_cycle", obs_rsp_k, 4);

        // Read data never arrives: timeout after T cycles in RD_WAIT.
        issue(2'b01, 17'h00100, 32'h0, 32'h0, 4'h3, 0, 1'b0, 1000, 0, 32'h1234_5678);
        wait_done();
        chk("t4_err", obs_err, 1'b1);
        chk("t4_rdata", obs_rdata, 32'h0);
        chk("t4_wait_cycles", obs_wait, T);
        chk("t4_rsp_cycle", obs_rsp_k, 2 + T);

        // Zero-latency slave after two stall cycles.
        issue(2'b01, 17'h00ABC, 32'h0, 32'h0, 4'hF, 2, 1'b1, 0, 0, 32'h0BAD_F00D);
        wait_done();
        chk("t5_wait_cycles", obs_wait, 0);
        chk("t5_rdata", obs_rdata, 32'h0BAD_F00D);
        chk("t5_rsp_cycle", obs_rsp_k, 4);

        // Reserved op behaves as a read with no error.
        issue(2'b11, 17'h00077, 32'h0, 32'h0, 4'h1, 0, 1'b0, 0, 0, 32'hCAFE_0001);
        wait_done();
        chk("t7_rsvd_rdata", obs_rdata, 32'hCAFE_0001);
        chk("t7_rsvd_err", obs_err, 1'b0);

        // Reset while a write is stalled.
        issue(2'b00, 17'h00300, 32'h1111_2222, 32'h0, 4'hF, 0, 1'b0, 0, 1000, 32'h0);
        @(posedge clk); #3;
        chk("t6_write_before_rst", avmm_write_o, 1'b1);
        p0 = rsp_pulses;
        rst_n = 1'b0;
        #1;
        chk("t6_write_dropped", avmm_write_o, 1'b0);
        chk("t6_ready_in_rst", cmd_ready, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_no_rsp", rsp_pulses, p0);
        chk("t6_ready_after", cmd_ready, 1'b1);

        for (int n = 0; n < 300; n++) begin
            issue(2'($urandom_range(0, 3)), 17'($urandom), $urandom, $urandom, 4'($urandom),
                  pick(), $urandom_range(0, 3) == 0, pick(), pick(), $urandom);
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
